// File: rtl/sound_pkg.sv
// Shared sound codes, scheduler state encoding and priority helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sound_pkg;

    // Codes shared with the speaker mux; numeric order doubles as priority order.
    typedef enum logic [1:0] {
        SND_OFF  = 2'b00,
        SND_WIN  = 2'b01,
        SND_LOSE = 2'b10,
        SND_VICT = 2'b11
    } snd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_GAP  = 2'b10,
        ST_LOCK = 2'b11
    } state_t;

    // True when code a outranks code b (vict > lose > win > off).
    function automatic logic prio_gt(input snd_t a, input snd_t b);
        return (a > b);
    endfunction

    // Collapse same-cycle event pulses to the single highest-priority code.
    function automatic snd_t ev_code(input logic win, input logic lose, input logic vict);
        if (vict)      return SND_VICT;
        else if (lose) return SND_LOSE;
        else if (win)  return SND_WIN;
        else           return SND_OFF;
    endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// Event/sound bundle between the game FSM, the scheduler and the speaker mux.
// Latency: n/a (wires only).
// Backpressure: none; events are fire-and-forget pulses.
// Ports: ev_win/ev_lose/ev_vict event pulses, clear (leave LOCK), mute,
//        sound_control code, busy, done pulse.
interface sound_scheduler_if;
    logic       ev_win;
    logic       ev_lose;
    logic       ev_vict;
    logic       clear;
    logic       mute;
    logic [1:0] sound_control;
    logic       busy;
    logic       done;

    modport master (
        output ev_win, ev_lose, ev_vict, clear, mute,
        input  sound_control, busy, done
    );

    modport slave (
        input  ev_win, ev_lose, ev_vict, clear, mute,
        output sound_control, busy, done
    );
endinterface

// File: rtl/sound_scheduler_tick_divider.sv
// Free-running tick generator: one-cycle tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV-1 cycles after the cycle following restart.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), restart (zero the divider), tick.
module tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart)  cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + W'(1);
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/sound_scheduler.sv
// Turns game-event pulses into timed sound codes with a silent gap and a one-deep pending slot.
// Latency: event in cycle N -> sound_control in cycle N+1 (registered outputs).
// Backpressure: none; excess/lower-priority events are silently dropped.
// Ports: clk, rst (sync, active-high), bus (slave side of sound_scheduler_if).
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int WIN_TICKS  = 300,
    parameter int LOSE_TICKS = 500,
    parameter int VICT_TICKS = 2000,
    parameter int GAP_TICKS  = 100,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    sound_scheduler_if.slave    bus
);
    state_t           state, state_nxt;
    snd_t             code, code_nxt, pend, pend_nxt, ev, pend_w;
    logic [CNT_W-1:0] tcnt, dur;
    logic             tick, restart, expired, done_nxt;
    logic [1:0]       sc_nxt;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign ev = ev_code(bus.ev_win, bus.ev_lose, bus.ev_vict);

    // Slot after this cycle's write; victory never lands here because it preempts.
    assign pend_w = ((ev == SND_WIN || ev == SND_LOSE) && prio_gt(ev, pend)) ? ev : pend;

    always_comb begin
        dur = CNT_W'(GAP_TICKS);
        if (state == ST_PLAY) begin
            case (code)
                SND_WIN:  dur = CNT_W'(WIN_TICKS);
                SND_LOSE: dur = CNT_W'(LOSE_TICKS);
                default:  dur = CNT_W'(VICT_TICKS);
            endcase
        end
    end

    // Last cycle of the current PLAY/GAP period.
    assign expired = tick && (tcnt == dur - CNT_W'(1));

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        pend_nxt  = pend;
        restart   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev != SND_OFF) begin
                    state_nxt = ST_PLAY;
                    code_nxt  = ev;
                    restart   = 1'b1;
                end
            end
            ST_PLAY: begin
                pend_nxt = pend_w;
                done_nxt = expired;
                if (ev == SND_VICT) begin
                    code_nxt = SND_VICT;
                    pend_nxt = SND_OFF;
                    restart  = 1'b1;
                end else if (expired) begin
                    state_nxt = (code == SND_VICT) ? ST_LOCK : ST_GAP;
                    restart   = 1'b1;
                end
            end
            ST_GAP: begin
                pend_nxt = pend_w;
                if (ev == SND_VICT) begin
                    state_nxt = ST_PLAY;
                    code_nxt  = SND_VICT;
                    pend_nxt  = SND_OFF;
                    restart   = 1'b1;
                end else if (expired) begin
                    if (pend_w != SND_OFF) begin
                        state_nxt = ST_PLAY;
                        code_nxt  = pend_w;
                        pend_nxt  = SND_OFF;
                        restart   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_LOCK: begin
                if (bus.clear) begin
                    state_nxt = ST_IDLE;
                    pend_nxt  = SND_OFF;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mute only blanks the output register; timing keeps running underneath.
    assign sc_nxt = (state_nxt == ST_PLAY && !bus.mute) ? code_nxt : SND_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            code              <= SND_OFF;
            pend              <= SND_OFF;
            tcnt              <= '0;
            bus.sound_control <= SND_OFF;
            bus.done          <= 1'b0;
        end else begin
            state             <= state_nxt;
            code              <= code_nxt;
            pend              <= pend_nxt;
            bus.sound_control <= sc_nxt;
            bus.done          <= done_nxt;
            if (restart)   tcnt <= '0;
            else if (tick) tcnt <= tcnt + CNT_W'(1);
        end
    end

    assign bus.busy = (state != ST_IDLE);
endmodule
